// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input line plus received-byte handshake and status pulses
//   rxd       - asynchronous serial line, idle high
//   rx_data   - last accepted byte
//   rx_valid  - rx_data holds an unconsumed byte
//   rx_ready  - consumer takes the byte when rx_valid and rx_ready are high on a clock edge
//   frame_err - one-cycle pulse, stop bit sampled low
//   overrun   - one-cycle pulse, completed byte dropped because the output was occupied
interface uart_rx_if;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  modport master (input rxd, rx_ready, output rx_data, rx_valid, frame_err, overrun);
  modport slave (output rxd, rx_ready, input rx_data, rx_valid, frame_err, overrun);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling, 3-sample majority vote and valid/ready output
//   clk_50m - single clock, rising edge
//   rst     - synchronous active-high reset
//   bus     - uart_rx_if master: rxd in, rx_ready in, rx_data/rx_valid/frame_err/overrun out
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input logic       clk_50m,
  input logic       rst,
  uart_rx_if.master bus
);
  localparam int OS_DIV = CLKS_PER_BIT / 16;
  localparam int CW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_state, w_next;
  logic          r_sync, r_rxs;
  logic [CW-1:0] r_os_cnt;
  logic [3:0]    r_idx;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift, r_data;
  logic          r_s7, r_s8, r_valid, r_frame_err, r_overrun;
  logic          w_tick, w_maj, w_mid, w_last, w_stop_done, w_load;
  assign w_tick = r_os_cnt == CW'(OS_DIV - 1);
  assign w_mid = w_tick && r_idx == 4'd9;
  assign w_last = w_tick && r_idx == 4'd15;
  // index-9 sample is the live rxs, combined with the two latched earlier samples
  assign w_maj = (r_s7 & r_s8) | (r_s7 & r_rxs) | (r_s8 & r_rxs);
  assign w_stop_done = w_mid && r_state == STOP;
  // a consumer taking the pending byte in this same cycle frees the slot for the new one
  assign w_load = w_stop_done && w_maj && (!r_valid || bus.rx_ready);
  assign bus.rx_data = r_data;
  assign bus.rx_valid = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun = r_overrun;
  always_ff @(posedge clk_50m)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (w_tick)
      case (r_state)
        IDLE:    w_next = r_rxs ? IDLE : START;
        START:   w_next = (w_mid && w_maj) ? IDLE : (w_last ? DATA : START);
        DATA:    w_next = (w_last && r_bit == 3'd7) ? STOP : DATA;
        STOP:    w_next = w_mid ? IDLE : STOP;
        default: w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_sync      <= 1'b1;
      r_rxs       <= 1'b1;
      r_os_cnt    <= '0;
      r_idx       <= 4'd0;
      r_bit       <= 3'd0;
      r_shift     <= 8'h00;
      r_s7        <= 1'b1;
      r_s8        <= 1'b1;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync   <= bus.rxd;
      r_rxs    <= r_sync;
      r_os_cnt <= w_tick ? '0 : r_os_cnt + CW'(1);
      if (w_tick) begin
        r_idx <= (r_state == IDLE) ? 4'd0 : r_idx + 4'd1;
        if (r_idx == 4'd7) r_s7 <= r_rxs;
        if (r_idx == 4'd8) r_s8 <= r_rxs;
        if (r_state == DATA && r_idx == 4'd9) r_shift <= {w_maj, r_shift[7:1]};
        if (r_state == START && r_idx == 4'd15) r_bit <= 3'd0;
        else if (r_state == DATA && r_idx == 4'd15) r_bit <= r_bit + 3'd1;
      end
      r_frame_err <= w_stop_done && !w_maj;
      r_overrun   <= w_stop_done && w_maj && !w_load;
      if (w_load) r_data <= r_shift;
      r_valid <= w_load || (r_valid && !bus.rx_ready);
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed 8N1 frames with a scoreboard of expected bytes and status pulses
module tb_uart_rx;
  localparam int CPB = 434;
  localparam int OSD = CPB / 16;
  localparam int K_BYTE = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR = 2;
  typedef struct {
    int         kind;
    logic [7:0] data;
  } evt_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   phase = 0;
  evt_t q[$];
  logic pv = 1'b0, pr = 1'b0, pfe = 1'b0, pov = 1'b0;
  uart_rx_if bus();
  uart_rx #(.CLKS_PER_BIT(CPB)) dut (.clk_50m(clk), .rst(rst), .bus(bus));
  always #10 clk = ~clk;
  // oversampling tick phase as seen during the cycle following each edge
  always @(posedge clk) phase <= rst ? 0 : (phase == OSD - 1 ? 0 : phase + 1);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic expect_evt(input int kind, input logic [7:0] data);
    evt_t e;
    e.kind = kind;
    e.data = data;
    q.push_back(e);
  endtask
  task automatic take(input int kind, input logic [7:0] data);
    evt_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %h expected nothing", kind, data);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.data !== data) begin
        errors++;
        $display("FAIL event: got kind %0d data %h expected kind %0d data %h", kind, data, e.kind, e.data);
      end
    end
  endtask
  always @(negedge clk) begin
    if (bus.rx_valid && (!pv || pr)) take(K_BYTE, bus.rx_data);
    if (bus.frame_err) begin
      take(K_FERR, 8'h00);
      chk("frame_err_width", {31'd0, pfe}, 32'd0);
    end
    if (bus.overrun) begin
      take(K_OVR, 8'h00);
      chk("overrun_width", {31'd0, pov}, 32'd0);
    end
    pv  = bus.rx_valid;
    pr  = bus.rx_ready;
    pfe = bus.frame_err;
    pov = bus.overrun;
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rxd = f[i];
      cyc(CPB);
    end
    bus.rxd = 1'b1;
  endtask
  task automatic drained(input string name);
    chk(name, q.size(), 32'd0);
  endtask
  initial begin
    #(20 * 95000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.rxd = 1'b1;
    bus.rx_ready = 1'b1;
    cyc(3);
    chk("reset_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("reset_data", {24'd0, bus.rx_data}, 32'd0);
    chk("reset_ferr", {31'd0, bus.frame_err}, 32'd0);
    chk("reset_ovr", {31'd0, bus.overrun}, 32'd0);
    rst = 1'b0;
    cyc(100);
    expect_evt(K_BYTE, 8'h55);
    send_byte(8'h55, 1'b1);
    cyc(600);
    drained("drain_55");
    chk("valid_pulse_55", {31'd0, bus.rx_valid}, 32'd0);
    chk("data_55", {24'd0, bus.rx_data}, 32'h55);
    bus.rx_ready = 1'b0;
    expect_evt(K_BYTE, 8'hA3);
    expect_evt(K_OVR, 8'h00);
    send_byte(8'hA3, 1'b1);
    send_byte(8'h0F, 1'b1);
    cyc(600);
    drained("drain_ovr");
    chk("hold_data_A3", {24'd0, bus.rx_data}, 32'hA3);
    chk("hold_valid_A3", {31'd0, bus.rx_valid}, 32'd1);
    bus.rx_ready = 1'b1;
    cyc(1);
    chk("consume_A3", {31'd0, bus.rx_valid}, 32'd0);
    bus.rxd = 1'b0;
    cyc(100);
    bus.rxd = 1'b1;
    cyc(600);
    drained("drain_glitch");
    chk("glitch_valid", {31'd0, bus.rx_valid}, 32'd0);
    expect_evt(K_BYTE, 8'hC8);
    send_byte(8'hC8, 1'b1);
    cyc(600);
    drained("drain_C8");
    expect_evt(K_FERR, 8'h00);
    send_byte(8'h7E, 1'b0);
    cyc(1000);
    drained("drain_ferr");
    chk("ferr_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("ferr_data_kept", {24'd0, bus.rx_data}, 32'hC8);
    expect_evt(K_BYTE, 8'h81);
    send_byte(8'h81, 1'b1);
    cyc(600);
    drained("drain_81");
    fork
      send_byte(8'hFF, 1'b1);
      begin
        cyc(4 * CPB + 200);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
    join
    cyc(600);
    drained("drain_abort");
    chk("abort_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("abort_data", {24'd0, bus.rx_data}, 32'd0);
    bus.rx_ready = 1'b0;
    expect_evt(K_BYTE, 8'h12);
    send_byte(8'h12, 1'b1);
    cyc(600);
    drained("drain_12");
    chk("data_12", {24'd0, bus.rx_data}, 32'h12);
    chk("valid_12", {31'd0, bus.rx_valid}, 32'd1);
    bus.rx_ready = 1'b1;
    cyc(1);
    bus.rx_ready = 1'b0;
    expect_evt(K_BYTE, 8'h33);
    send_byte(8'h33, 1'b1);
    cyc(600);
    drained("drain_33");
    chk("pending_33", {24'd0, bus.rx_data}, 32'h33);
    // start edge placed so the first rxs-low cycle is a tick; the stop index-9 tick is then 154 ticks later
    while (phase != OSD - 3) cyc(1);
    expect_evt(K_BYTE, 8'h34);
    fork
      send_byte(8'h34, 1'b1);
      begin
        cyc(2 + 154 * OSD);
        bus.rx_ready = 1'b1;
        cyc(1);
        bus.rx_ready = 1'b0;
      end
    join
    cyc(600);
    drained("drain_34");
    chk("data_34", {24'd0, bus.rx_data}, 32'h34);
    chk("valid_34", {31'd0, bus.rx_valid}, 32'd1);
    chk("ovr_34", {31'd0, bus.overrun}, 32'd0);
    bus.rx_ready = 1'b1;
    cyc(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_BIT, default 434, meaning clk_50m cycles per serial bit (115200 baud at 50 MHz).
REQ-002 The block SHALL have port clk_50m, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-005 The block SHALL have port rx_data, output, 8 bits: last accepted byte.
REQ-006 The block SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-007 The block SHALL have port rx_ready, input, 1 bit: consumer takes the byte when rx_valid and rx_ready are both high on a rising edge.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse, stop bit sampled low.
REQ-009 The block SHALL have port overrun, output, 1 bit: one-cycle pulse, completed byte dropped because the output was still occupied.

Function
REQ-010 The block SHALL pass rxd through a two-flop synchronizer (both flops reset to 1); all decisions use the second flop, rxs.
REQ-011 The block SHALL generate a 16x oversampling tick from a free-running counter 0..OS_DIV-1, where OS_DIV = CLKS_PER_BIT/16 (integer, 27 at default), with the tick high for one cycle when the counter equals OS_DIV-1.
REQ-012 The block SHALL define one bit period as 16 ticks (432 clocks at default), tracked by a 4-bit sample index that wraps 15->0.
REQ-013 The block SHALL implement states IDLE, START, DATA and STOP, with all state changes and sampling occurring only on tick cycles.
REQ-014 In IDLE, on a tick with rxs=0, the block SHALL clear the sample index to 0 and enter START.
REQ-015 The block SHALL latch rxs at sample indices 7, 8 and 9 and, at index 9, take the bit value as the majority of those three samples.
REQ-016 In START, if the majority at index 9 is 1 (false start), the block SHALL return to IDLE; otherwise, at index 15, it SHALL enter DATA with the bit counter at 0.
REQ-017 In DATA, the block SHALL shift each majority bit into an 8-bit shift register LSB first at index 9, enter STOP at index 15 of bit 7, and otherwise increment the bit counter.
REQ-018 In STOP, at index 9, the block SHALL return to IDLE in the same cycle, so that the next start edge is detectable from the following tick onward.
REQ-019 If the STOP majority is 0, the block SHALL pulse frame_err for one cycle, discard the byte, and leave rx_data and rx_valid unchanged.
REQ-020 If the STOP majority is 1 and the output is free (rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle), the block SHALL load rx_data and set rx_valid on the next edge.
REQ-021 If the STOP majority is 1 and rx_valid=1 with rx_ready=0, the block SHALL pulse overrun for one cycle, drop the new byte, and retain the old byte.
REQ-022 When rx_valid=1 and rx_ready=1 with no simultaneous load, the block SHALL clear rx_valid on that edge; rx_data SHALL hold its value.
REQ-023 Latency SHALL be as follows: rx_valid rises one clock after the STOP index-9 tick, which is about 9.5 bit periods after the start edge.
REQ-024 rx_ready SHALL be ignored while rx_valid=0.

Reset
REQ-025 While rst is high at a rising edge, the block SHALL force: state IDLE; tick counter, sample index, bit counter and shift register 0; synchronizer flops 1; rx_data 0x00; rx_valid, frame_err and overrun 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no output; after release, the block SHALL resynchronize on the next high-to-low transition of rxs seen in IDLE. A line held low through reset release SHALL be treated as a start.
REQ-027 rst SHALL take priority over every other event in the same cycle.

Verification
REQ-028 The bench SHALL drive byte 0x55 (8N1, 434-clock bits) with rx_ready=1 and check that rx_valid pulses for 1 cycle with rx_data=0x55, and that frame_err=0 and overrun=0.
REQ-029 The bench SHALL drive 0xA3 then 0x0F back-to-back with rx_ready=0 and check: rx_data=0xA3 and rx_valid=1 after the first byte; a single overrun pulse after the second; rx_data still 0xA3.
REQ-030 The bench SHALL drive a 100-clock low glitch on idle rxd and check that the block returns to IDLE with no rx_valid and no frame_err; a following byte 0xC8 is then received correctly.
REQ-031 The bench SHALL drive byte 0x7E with the stop bit held low and check a single frame_err pulse with rx_valid remaining 0; the next well-formed byte 0x81 is then received.
REQ-032 The bench SHALL assert rst for 1 cycle during data bit 3 of 0xFF, release it, then send 0x12, and check that no output results from the aborted frame and that rx_data=0x12 with rx_valid=1.
REQ-033 The bench SHALL hold rx_ready high in the exact cycle a new byte 0x34 completes while 0x33 is pending, and check that 0x33 is consumed, rx_data becomes 0x34 with rx_valid=1, and overrun=0.
